// File: rtl/mux_tree_pipe_if.sv
// Handshake/data bundle for mux_tree_pipe.
// master drives en/in_valid/sel/in and receives out/out_valid/out_err;
// slave is the mux side.
//   en        pipeline advance (low = stall)
//   in_valid  qualifies sel/in this cycle
//   sel       word index, word k at in[k*WIDTH +: WIDTH]
//   in        N packed words
//   out       selected word (registered)
//   out_valid out/out_err belong to an accepted selection
//   out_err   accepted sel was >= N, out forced to 0
interface mux_tree_pipe_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 32
);
    localparam int unsigned SELW = $clog2(N);

    logic                 en;
    logic                 in_valid;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 out_err;

    modport master (
        output en, in_valid, sel, in,
        input  out, out_valid, out_err
    );

    modport slave (
        input  en, in_valid, sel, in,
        output out, out_valid, out_err
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux of WIDTH-bit words built as a binary tree of 2:1
// selects, one register stage per tree level (latency = $clog2(N)).
// Valid and out-of-range flags travel with each selection; en = 0 stalls
// every stage. Reset is synchronous, active-high.
//   clk    rising-edge clock
//   reset  synchronous active-high reset, priority over en
//   bus    mux_tree_pipe_if.slave (en, in_valid, sel, in -> out, out_valid, out_err)
module mux_tree_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 32
) (
    input  logic            clk,
    input  logic            reset,
    mux_tree_pipe_if.slave  bus
);
    localparam int unsigned SELW   = $clog2(N);
    localparam int unsigned LEAVES = 1 << SELW;

    // Leaves padded to a power of two; missing words read as zero.
    logic [LEAVES-1:0][WIDTH-1:0] leaf_c;
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N) begin : g_in
            assign leaf_c[k] = bus.in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign leaf_c[k] = '0;
        end
    end

    // Out-of-range flag, decided once at the tree input.
    logic err_c;
    assign err_c = ({1'b0, bus.sel} >= (SELW+1)'(N));

    // Inner levels 0..SELW-2; each consumes sel bit j and keeps the rest.
    for (genvar j = 0; j < SELW - 1; j++) begin : g_lvl
        localparam int unsigned NW = LEAVES >> (j + 1);
        localparam int unsigned RS = SELW - j - 1;

        logic [2*NW-1:0][WIDTH-1:0] win_c;
        logic [RS:0]                sin_c;
        logic                       vin_c;
        logic                       ein_c;
        logic [NW-1:0][WIDTH-1:0]   data_d;
        logic [NW-1:0][WIDTH-1:0]   data_q;
        logic [RS-1:0]              sel_q;
        logic                       valid_q;
        logic                       err_q;

        if (j == 0) begin : g_src
            assign win_c = leaf_c;
            assign sin_c = bus.sel;
            assign vin_c = bus.in_valid;
            assign ein_c = err_c;
        end else begin : g_src
            assign win_c = g_lvl[j-1].data_q;
            assign sin_c = g_lvl[j-1].sel_q;
            assign vin_c = g_lvl[j-1].valid_q;
            assign ein_c = g_lvl[j-1].err_q;
        end

        for (genvar i = 0; i < NW; i++) begin : g_pair
            assign data_d[i] = sin_c[0] ? win_c[2*i+1] : win_c[2*i];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q  <= '0;
                sel_q   <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (bus.en) begin
                data_q  <= data_d;
                sel_q   <= sin_c[RS:1];
                valid_q <= vin_c;
                err_q   <= ein_c;
            end
        end
    end

    // Final level feeds the output registers directly.
    logic [1:0][WIDTH-1:0] fwin_c;
    logic                  fsel_c;
    logic                  fvin_c;
    logic                  fein_c;

    if (SELW == 1) begin : g_fsrc
        assign fwin_c = leaf_c;
        assign fsel_c = bus.sel[0];
        assign fvin_c = bus.in_valid;
        assign fein_c = err_c;
    end else begin : g_fsrc
        assign fwin_c = g_lvl[SELW-2].data_q;
        assign fsel_c = g_lvl[SELW-2].sel_q[0];
        assign fvin_c = g_lvl[SELW-2].valid_q;
        assign fein_c = g_lvl[SELW-2].err_q;
    end

    // out only updates for valid slots so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
        end else if (bus.en) begin
            bus.out_valid <= fvin_c;
            bus.out_err   <= fvin_c & fein_c;
            if (fvin_c) begin
                bus.out <= fein_c ? '0 : (fsel_c ? fwin_c[1] : fwin_c[0]);
            end
        end
    end
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three instances (N=32/W=64, N=20/W=64, N=2/W=8)
// driven in lockstep; each is compared against a latency-queue model.
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_tree_pipe_if #(.WIDTH(64), .N(32)) ifa ();
    mux_tree_pipe_if #(.WIDTH(64), .N(20)) ifb ();
    mux_tree_pipe_if #(.WIDTH(8),  .N(2))  ifc ();

    mux_tree_pipe #(.WIDTH(64), .N(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mux_tree_pipe #(.WIDTH(64), .N(20)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    mux_tree_pipe #(.WIDTH(8),  .N(2))  dut_c (.clk(clk), .reset(reset), .bus(ifc));

    typedef struct packed {
        logic        v;
        logic        err;
        logic [63:0] data;
    } ent_t;

    ent_t        q [3][$];
    int          nn  [3] = '{32, 20, 2};
    int          lat [3] = '{5, 5, 1};
    logic        d_en  [3];
    logic        d_v   [3];
    logic [4:0]  d_sel [3];
    logic [63:0] w [3][32];
    logic        ev [3];
    logic        ee [3];
    logic [63:0] eo [3];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        ifa.en = d_en[0]; ifa.in_valid = d_v[0]; ifa.sel = d_sel[0];
        ifb.en = d_en[1]; ifb.in_valid = d_v[1]; ifb.sel = d_sel[1];
        ifc.en = d_en[2]; ifc.in_valid = d_v[2]; ifc.sel = d_sel[2][0];
        for (int k = 0; k < 32; k++) ifa.in[k*64 +: 64] = w[0][k];
        for (int k = 0; k < 20; k++) ifb.in[k*64 +: 64] = w[1][k];
        for (int k = 0; k < 2; k++)  ifc.in[k*8 +: 8]   = w[2][k][7:0];
    endtask

    task automatic observe(input int d, output logic v, output logic e, output logic [63:0] o);
        case (d)
            0:       begin v = ifa.out_valid; e = ifa.out_err; o = ifa.out; end
            1:       begin v = ifb.out_valid; e = ifb.out_err; o = ifb.out; end
            default: begin v = ifc.out_valid; e = ifc.out_err; o = {56'b0, ifc.out}; end
        endcase
    endtask

    // One clock: present inputs, advance the models, compare every instance.
    task automatic step();
        ent_t        e;
        logic        ov;
        logic        oe;
        logic [63:0] oo;
        apply();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                q[d].delete();
                ev[d] = 1'b0;
                ee[d] = 1'b0;
                eo[d] = 64'h0;
            end else if (d_en[d]) begin
                e.v    = d_v[d];
                e.err  = (int'(d_sel[d]) >= nn[d]);
                e.data = e.err ? 64'h0 : w[d][d_sel[d]];
                q[d].push_back(e);
                if (q[d].size() >= lat[d]) begin
                    e     = q[d].pop_front();
                    ev[d] = e.v;
                    ee[d] = e.v & e.err;
                    if (e.v) eo[d] = e.data;
                end
            end
            observe(d, ov, oe, oo);
            check($sformatf("d%0d_out_valid", d), {63'b0, ov}, {63'b0, ev[d]});
            check($sformatf("d%0d_out_err", d), {63'b0, oe}, {63'b0, ee[d]});
            if (ev[d] || reset) check($sformatf("d%0d_out", d), oo, eo[d]);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            d_en[d] = 1'b1;
            d_v[d]  = 1'b0;
        end
    endtask

    initial begin
        int bub_v   [5] = '{1, 0, 1, 1, 0};
        int bub_sel [5] = '{3, 5, 17, 31, 9};
        int oor_sel [3] = '{19, 20, 31};

        reset = 1'b1;
        idle();
        for (int d = 0; d < 3; d++) begin
            d_sel[d] = 5'd0;
            for (int k = 0; k < 32; k++) w[d][k] = {$urandom, $urandom};
        end
        for (int k = 0; k < 32; k++) w[0][k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        w[2][0] = 64'h0000_0000_0000_00C3;
        w[2][1] = 64'h0000_0000_0000_005A;
        step();
        step();
        reset = 1'b0;

        // Sweep every index on A, random in-range on B, alternating on C.
        for (int k = 0; k < 32; k++) begin
            for (int d = 0; d < 3; d++) d_v[d] = 1'b1;
            d_sel[0] = 5'(k);
            d_sel[1] = 5'($urandom_range(0, 19));
            d_sel[2] = 5'(k % 2);
            step();
            if (k == 4)  check("sweep_first", ifa.out, 64'hA5A5_0000_0000_0000);
            if (k == 31) check("sweep_last", ifa.out, 64'hA5A5_0000_0000_001B);
            if (k == 0)  check("min_sel0", {56'b0, ifc.out}, 64'hC3);
            if (k == 1)  check("min_sel1", {56'b0, ifc.out}, 64'h5A);
        end
        idle();
        repeat (6) step();

        // Bubble pattern on A.
        for (int i = 0; i < 5; i++) begin
            idle();
            d_v[0]   = 1'(bub_v[i]);
            d_sel[0] = 5'(bub_sel[i]);
            step();
        end
        idle();
        repeat (6) step();

        // Stall A for four cycles between the second and third selection.
        idle();
        d_v[0] = 1'b1; d_sel[0] = 5'd7; step();
        d_v[0] = 1'b1; d_sel[0] = 5'd8; step();
        for (int i = 0; i < 4; i++) begin
            d_en[0]  = 1'b0;
            d_v[0]   = 1'($urandom_range(0, 1));
            d_sel[0] = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        d_v[0] = 1'b1; d_sel[0] = 5'd9; step();
        idle();
        repeat (6) step();

        // Out-of-range selections on B (N = 20).
        for (int i = 0; i < 8; i++) begin
            idle();
            d_v[1]   = (i < 3);
            d_sel[1] = (i < 3) ? 5'(oor_sel[i]) : 5'd0;
            step();
            if (i == 4) begin
                check("oor_in_range_out", ifb.out, w[1][19]);
                check("oor_in_range_err", {63'b0, ifb.out_err}, 64'h0);
            end
            if (i == 6) begin
                check("oor_31_out", ifb.out, 64'h0);
                check("oor_31_err", {63'b0, ifb.out_err}, 64'h1);
            end
        end

        // Reset with selections in flight, then a fresh selection.
        for (int k = 1; k <= 3; k++) begin
            idle();
            d_v[0] = 1'b1; d_sel[0] = 5'(k);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        check("mid_reset_out", ifa.out, 64'h0);
        reset = 1'b0;
        d_v[0] = 1'b1; d_sel[0] = 5'd4; step();
        idle();
        repeat (3) step();
        step();
        check("post_reset_sel4", ifa.out, 64'hA5A5_0000_0000_0004);
        check("post_reset_valid", {63'b0, ifa.out_valid}, 64'h1);
        repeat (2) step();

        // Reset while stalled.
        idle();
        d_v[0] = 1'b1; d_sel[0] = 5'd5; step();
        for (int d = 0; d < 3; d++) d_en[d] = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        repeat (6) step();

        // Random traffic with stalls, bubbles, out-of-range and rare resets.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 3; d++) begin
                d_en[d] = ($urandom_range(0, 3) != 0);
                d_v[d]  = 1'($urandom_range(0, 1));
            end
            d_sel[0] = 5'($urandom_range(0, 31));
            d_sel[1] = 5'($urandom_range(0, 31));
            d_sel[2] = 5'($urandom_range(0, 1));
            if (n % 16 == 0) begin
                w[0][$urandom_range(0, 31)] = {$urandom, $urandom};
                w[1][$urandom_range(0, 19)] = {$urandom, $urandom};
                w[2][$urandom_range(0, 1)]  = 64'($urandom_range(0, 255));
            end
            step();
        end
        reset = 1'b0;
        idle();
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
